// File: rtl/ssd1306_spi_sink.sv
// Panel-side SSD1306 4-wire SPI receiver: oversamples the serial link, assembles
// mode-0 bytes and decodes the command set into display state and GDDRAM writes.
module ssd1306_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int COL_W       = 7,
  parameter int PAGE_W      = 3
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    sdin,
  input  logic                    ss,
  input  logic                    dc,
  input  logic                    res_n,
  output logic                    ram_we,
  output logic [PAGE_W+COL_W-1:0] ram_addr,
  output logic [7:0]              ram_wdata,
  output logic                    display_on,
  output logic                    invert,
  output logic                    all_on,
  output logic [7:0]              contrast,
  output logic [5:0]              start_line,
  output logic                    charge_pump,
  output logic                    cmd_err
);

  localparam int AW = PAGE_W + COL_W;

  typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_e;

  typedef struct packed {
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [7:0]        ram_wdata;
    logic              display_on;
    logic              invert;
    logic              all_on;
    logic [7:0]        contrast;
    logic [5:0]        start_line;
    logic              charge_pump;
    logic              cmd_err;
    logic [1:0]        mem_mode;
    logic [COL_W-1:0]  col, col_start, col_end;
    logic [PAGE_W-1:0] page, page_start, page_end;
    logic [7:0]        op;
    logic [COL_W-1:0]  arg;
  } ctl_t;

  function automatic ctl_t ctl_reset();
    ctl_t c;
    c            = '0;
    c.contrast   = 8'h7F;
    c.mem_mode   = 2'd2;
    c.col_end    = '1;
    c.page_end   = '1;
    return c;
  endfunction

  // Pin order {res_n, dc, ss, sdin, sclk}; ss idles deasserted while in reset.
  localparam logic [4:0] SYNC_RST = 5'b00100;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic res_n_s, dc_s, ss_s, sdin_s, sclk_s;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{SYNC_RST}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], {res_n, dc, ss, sdin, sclk}};
  end

  assign {res_n_s, dc_s, ss_s, sdin_s, sclk_s} = sync_q[SYNC_STAGES-1];

  logic       sclk_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       rx_valid_q;
  logic [7:0] rx_byte_q;
  logic       rx_dc_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      rx_dc_q     <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      sclk_prev_q <= sclk_s;
      if (!res_n_s) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
        rx_byte_q <= '0;
        rx_dc_q   <= 1'b0;
      end else if (ss_s) begin
        bit_cnt_q <= '0;
      end else if (sclk_s && !sclk_prev_q) begin
        shift_q   <= {shift_q[5:0], sdin_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_valid_q <= 1'b1;
          rx_byte_q  <= {shift_q, sdin_s};
          rx_dc_q    <= dc_s;
        end
      end
    end
  end

  state_e            state_q;
  ctl_t              ctl_q;
  logic [COL_W-1:0]  col_nxt;
  logic [PAGE_W-1:0] page_nxt;

  // Pointer advance after a data write; end < start wraps through the full range.
  // NOTE: both outputs get a default first so this block can never infer a latch.
  always_comb begin
    col_nxt  = ctl_q.col + COL_W'(1);
    page_nxt = ctl_q.page;
    case (ctl_q.mem_mode)
      2'd0: begin
        if (ctl_q.col == ctl_q.col_end) begin
          col_nxt  = ctl_q.col_start;
          page_nxt = (ctl_q.page == ctl_q.page_end) ? ctl_q.page_start
                                                    : ctl_q.page + PAGE_W'(1);
        end
      end
      2'd1: begin
        col_nxt = ctl_q.col;
        if (ctl_q.page == ctl_q.page_end) begin
          page_nxt = ctl_q.page_start;
          col_nxt  = (ctl_q.col == ctl_q.col_end) ? ctl_q.col_start
                                                  : ctl_q.col + COL_W'(1);
        end else begin
          page_nxt = ctl_q.page + PAGE_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctl_q   <= ctl_reset();
    end else if (!res_n_s) begin
      // Panel reset wins over a byte completing in the same cycle.
      state_q <= IDLE;
      ctl_q   <= ctl_reset();
    end else begin
      ctl_q.ram_we <= 1'b0;
      if (rx_valid_q) begin
        if (rx_dc_q) begin
          state_q         <= IDLE;
          ctl_q.ram_we    <= 1'b1;
          ctl_q.ram_addr  <= {ctl_q.page, ctl_q.col};
          ctl_q.ram_wdata <= rx_byte_q;
          ctl_q.col       <= col_nxt;
          ctl_q.page      <= page_nxt;
        end else begin
          case (state_q)
            IDLE: begin
              case (rx_byte_q) inside
                8'hAE, 8'hAF:  ctl_q.display_on <= rx_byte_q[0];
                8'hA4, 8'hA5:  ctl_q.all_on     <= rx_byte_q[0];
                8'hA6, 8'hA7:  ctl_q.invert     <= rx_byte_q[0];
                [8'h40:8'h7F]: ctl_q.start_line <= rx_byte_q[5:0];
                [8'h00:8'h0F]: ctl_q.col[3:0]   <= rx_byte_q[3:0];
                [8'h10:8'h17]: ctl_q.col[6:4]   <= rx_byte_q[2:0];
                [8'hB0:8'hB7]: ctl_q.page       <= rx_byte_q[PAGE_W-1:0];
                8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB,
                8'h21, 8'h22: begin
                  ctl_q.op <= rx_byte_q;
                  state_q  <= ARG1;
                end
                default: ctl_q.cmd_err <= 1'b1;
              endcase
            end
            ARG1: begin
              state_q <= IDLE;
              case (ctl_q.op)
                8'h81: ctl_q.contrast <= rx_byte_q;
                8'h20: begin
                  if (rx_byte_q[1:0] == 2'd3) ctl_q.cmd_err  <= 1'b1;
                  else                        ctl_q.mem_mode <= rx_byte_q[1:0];
                end
                8'h8D: ctl_q.charge_pump <= rx_byte_q[2];
                8'h21, 8'h22: begin
                  ctl_q.arg <= rx_byte_q[COL_W-1:0];
                  state_q   <= ARG2;
                end
                default: ;
              endcase
            end
            ARG2: begin
              state_q <= IDLE;
              if (ctl_q.op == 8'h21) begin
                ctl_q.col_start <= ctl_q.arg;
                ctl_q.col_end   <= rx_byte_q[COL_W-1:0];
                ctl_q.col       <= ctl_q.arg;
              end else begin
                ctl_q.page_start <= ctl_q.arg[PAGE_W-1:0];
                ctl_q.page_end   <= rx_byte_q[PAGE_W-1:0];
                ctl_q.page       <= ctl_q.arg[PAGE_W-1:0];
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign ram_we      = ctl_q.ram_we;
  assign ram_addr    = ctl_q.ram_addr;
  assign ram_wdata   = ctl_q.ram_wdata;
  assign display_on  = ctl_q.display_on;
  assign invert      = ctl_q.invert;
  assign all_on      = ctl_q.all_on;
  assign contrast    = ctl_q.contrast;
  assign start_line  = ctl_q.start_line;
  assign charge_pump = ctl_q.charge_pump;
  assign cmd_err     = ctl_q.cmd_err;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Bench for ssd1306_spi_sink: SPI byte driver, byte-stream reference model of the
// panel, and a write scoreboard drained by an independent monitor.
module tb_ssd1306_spi_sink;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sclk    = 1'b0;
  logic       sdin    = 1'b0;
  logic       ss      = 1'b1;
  logic       dc      = 1'b0;
  logic       res_n   = 1'b1;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       display_on, invert, all_on, charge_pump, cmd_err;
  logic [7:0] contrast;
  logic [5:0] start_line;

  ssd1306_spi_sink dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .sdin       (sdin),
    .ss         (ss),
    .dc         (dc),
    .res_n      (res_n),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .display_on (display_on),
    .invert     (invert),
    .all_on     (all_on),
    .contrast   (contrast),
    .start_line (start_line),
    .charge_pump(charge_pump),
    .cmd_err    (cmd_err)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: panel state plus pending command bytes.
  logic        m_disp, m_inv, m_allon, m_cp, m_err;
  logic [7:0]  m_contrast;
  logic [5:0]  m_sline;
  int          m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  logic [7:0]  m_pend[$];
  logic [17:0] exp_q[$];

  task automatic model_reset();
    m_disp = 0; m_inv = 0; m_allon = 0; m_cp = 0; m_err = 0;
    m_contrast = 8'h7F; m_sline = 0;
    m_mode = 2; m_col = 0; m_page = 0;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_pend.delete();
  endtask

  function automatic int nargs(input logic [7:0] op);
    if (op inside {8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) return 1;
    if (op == 8'h21 || op == 8'h22) return 2;
    if (op inside {8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7}) return 0;
    if (op <= 8'h17 || (op >= 8'h40 && op <= 8'h7F) || (op >= 8'hB0 && op <= 8'hB7)) return 0;
    return -1;
  endfunction

  task automatic model_apply(input logic [7:0] op, input int a1, input int a2);
    if (op == 8'hAE || op == 8'hAF) m_disp = (op == 8'hAF);
    else if (op == 8'hA4 || op == 8'hA5) m_allon = (op == 8'hA5);
    else if (op == 8'hA6 || op == 8'hA7) m_inv = (op == 8'hA7);
    else if (op >= 8'h40 && op <= 8'h7F) m_sline = 6'(op - 8'h40);
    else if (op <= 8'h0F) m_col = (m_col / 16) * 16 + int'(op);
    else if (op <= 8'h17) m_col = (int'(op) - 16) * 16 + m_col % 16;
    else if (op >= 8'hB0 && op <= 8'hB7) m_page = int'(op) - 'hB0;
    else if (op == 8'h81) m_contrast = 8'(a1);
    else if (op == 8'h20) begin
      if (a1 % 4 == 3) m_err = 1;
      else m_mode = a1 % 4;
    end
    else if (op == 8'h8D) m_cp = (a1 / 4) % 2 == 1;
    else if (op == 8'h21) begin m_cs = a1 % 128; m_ce = a2 % 128; m_col = m_cs; end
    else if (op == 8'h22) begin m_ps = a1 % 8; m_pe = a2 % 8; m_page = m_ps; end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic is_data);
    int n;
    if (is_data) begin
      m_pend.delete();
      exp_q.push_back({10'(m_page * 128 + m_col), b});
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          m_col  = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else begin
      m_pend.push_back(b);
      n = nargs(m_pend[0]);
      if (n < 0) begin
        m_err = 1;
        m_pend.delete();
      end else if (m_pend.size() == n + 1) begin
        model_apply(m_pend[0], (n > 0) ? int'(m_pend[1]) : 0, (n > 1) ? int'(m_pend[2]) : 0);
        m_pend.delete();
      end
    end
  endtask

  task automatic check_status();
    check("display_on",  display_on,  m_disp);
    check("invert",      invert,      m_inv);
    check("all_on",      all_on,      m_allon);
    check("contrast",    contrast,    m_contrast);
    check("start_line",  start_line,  m_sline);
    check("charge_pump", charge_pump, m_cp);
    check("cmd_err",     cmd_err,     m_err);
    check("ram_we_idle", ram_we,      1'b0);
  endtask

  // Drives the first nbits of b MSB-first in mode 0; sclk half period = 5 clk.
  task automatic spi_bits(input logic [7:0] b, input logic d, input int nbits);
    @(negedge clk_50M);
    ss = 1'b0;
    dc = d;
    repeat (5) @(negedge clk_50M);
    for (int i = 0; i < nbits; i++) begin
      sdin = b[7-i];
      repeat (5) @(negedge clk_50M);
      sclk = 1'b1;
      repeat (5) @(negedge clk_50M);
      sclk = 1'b0;
    end
  endtask

  // Full byte, then status compared 12 clk after the 8th rising edge.
  task automatic send(input logic [7:0] b, input logic d);
    model_byte(b, d);
    spi_bits(b, d, 8);
    repeat (7) @(negedge clk_50M);
    check_status();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ss    = 1'b1;
    sclk  = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_50M);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_addr"},  ram_addr,  10'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 8'd0);
    check_status();
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk_50M);
      if (ram_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write", ram_addr, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", ram_addr,  e[17:8]);
          check("wr_data", ram_wdata, e[7:0]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] singles [6] = '{8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
  logic [7:0] argops  [12] = '{8'h81, 8'h20, 8'h20, 8'h8D, 8'hA8, 8'hD3,
                               8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h21, 8'h22};

  initial begin
    int         r, nmax;
    logic [7:0] op, a;

    do_reset();
    check_reset_outputs("reset");

    send(8'hAF, 1'b0);
    send(8'h81, 1'b0); send(8'h3C, 1'b0);
    send(8'h81, 1'b0); send(8'h55, 1'b1);
    send(8'hA7, 1'b0);

    do_reset();
    send(8'h20, 1'b0); send(8'h00, 1'b0);
    send(8'h20, 1'b0); send(8'h03, 1'b0);
    send(8'h21, 1'b0); send(8'h7E, 1'b0); send(8'h7F, 1'b0);
    send(8'h22, 1'b0); send(8'h07, 1'b0); send(8'h07, 1'b0);
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);

    do_reset();
    send(8'hB3, 1'b0); send(8'h0F, 1'b0); send(8'h17, 1'b0);
    send(8'hAA, 1'b1); send(8'hBB, 1'b1);

    // Partial byte abandoned by ss, then sclk activity while deselected.
    do_reset();
    spi_bits(8'hF0, 1'b1, 5);
    ss = 1'b1;
    repeat (6) @(negedge clk_50M);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; repeat (5) @(negedge clk_50M);
      sclk = 1'b0; repeat (5) @(negedge clk_50M);
    end
    send(8'hA7, 1'b0);

    do_reset();
    for (int t = 0; t < 140; t++) begin
      r = $urandom_range(0, 99);
      if (r < 30) send(8'($urandom_range(0, 255)), 1'b1);
      else if (r < 42) send(singles[$urandom_range(0, 5)], 1'b0);
      else if (r < 50) send(8'(8'h40 + $urandom_range(0, 63)), 1'b0);
      else if (r < 58) send(8'($urandom_range(0, 8'h17)), 1'b0);
      else if (r < 64) send(8'(8'hB0 + $urandom_range(0, 7)), 1'b0);
      else begin
        op = argops[$urandom_range(0, 11)];
        send(op, 1'b0);
        nmax = (op == 8'h21 || op == 8'h22) ? 2 : 1;
        for (int k = 0; k < nmax; k++) begin
          if ($urandom_range(0, 9) == 0) begin
            send(8'($urandom_range(0, 255)), 1'b1);
            break;
          end
          if (op == 8'h20) a = {6'($urandom_range(0, 63)), 2'($urandom_range(0, 2))};
          else             a = 8'($urandom_range(0, 255));
          send(a, 1'b0);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        ss = 1'b1;
        repeat (3) @(negedge clk_50M);
      end
    end

    send(8'hFF, 1'b0);
    send(8'hAF, 1'b0);

    // Panel reset in the middle of a byte; the following byte must decode cleanly.
    spi_bits(8'h5A, 1'b0, 4);
    res_n = 1'b0;
    repeat (5) @(negedge clk_50M);
    model_reset();
    res_n = 1'b1;
    repeat (6) @(negedge clk_50M);
    check_reset_outputs("res_n");
    send(8'hAF, 1'b0);
    send(8'h81, 1'b0); send(8'h10, 1'b0);

    ss = 1'b1;
    repeat (20) @(negedge clk_50M);
    check("writes_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
